mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Parametrised next-generation MEM-stage data-memory access unit. It sits between the EX/MEM buffer and the data cache port.
- Replaces fire-and-forget dmem strobes with a request/response FSM that holds the pipeline until dmem_resp.
- Supports DATA_W of 32 or 64 bits.
- Detects misaligned accesses and suppresses them.
- Holds the aligned, sign-extended load result stable for forwarding and writeback until the pipeline advances.

Parameters:
DATA_W, 32, data bus width in bits (32 or 64); byte lanes NB = DATA_W/8, offset width OFS_W = log2(NB).
ADDR_W, 32, address width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  EX/MEM entry valid
req_load  in  1  entry is a load
req_store  in  1  entry is a store
req_funct3  in  3  load/store width and sign (b/h/w/d, unsigned variants)
req_addr  in  ADDR_W  byte address (alu result)
req_wdata  in  DATA_W  store data, right-justified
advance  in  1  pipeline advancing past MEM this cycle
dmem_address  out  ADDR_W  bus-aligned address (low OFS_W bits zero)
dmem_read  out  1  read request, registered
dmem_write  out  1  write request, registered
dmem_byte_enable  out  NB  write byte mask
dmem_wdata  out  DATA_W  lane-shifted store data
dmem_rdata  in  DATA_W  read data
dmem_resp  in  1  memory response, one-cycle pulse
stall  out  1  hold IF..MEM
done  out  1  result/completion valid
load_data  out  DATA_W  aligned, extended load result
rmask  out  NB  read byte mask (for rvfi)
wmask  out  NB  write byte mask (for rvfi)
misaligned  out  1  current access misaligned, no memory access issued

Behaviour:
- Reset (async, rst=1): state IDLE. Outputs:
  - dmem_read=0, dmem_write=0, dmem_byte_enable=0, dmem_wdata=0, dmem_address=0.
  - done=0, load_data=0, misaligned=0, rmask=0, wmask=0.
  - stall=0 unless req_valid and (req_load or req_store).
  - A reset mid-ACCESS drops dmem_read/dmem_write immediately.
- States: IDLE, ACCESS, HOLD.
- IDLE:
  - Memory request present (req_valid and req_load|req_store): stall=1. Capture funct3, addr, wdata, and load/store into internal registers.
    - Aligned: go to ACCESS. dmem_read or dmem_write registers high next cycle.
    - Misaligned: go to HOLD with misaligned=1, no dmem strobe.
  - Non-memory valid entry: stall=0, done=1 combinationally, no state change.
  - dmem_resp in IDLE is ignored.
- ACCESS:
  - Strobes, address, byte_enable and wdata are stable, driven from the captured registers. stall=1.
  - On dmem_resp: latch the extracted load_data (loads only; stores leave load_data unchanged), drop strobes the same edge, go to HOLD.
- HOLD: stall=0, done=1; load_data, rmask, wmask and misaligned are held.
  - advance=1: go to IDLE and clear done/misaligned. The next request is evaluated the following cycle.
  - advance=0: remain in HOLD.
- Latency: request seen at cycle 0; strobe from cycle 1; dmem_resp at cycle k≥1; done at cycle k+1.
- Alignment and masks: ofs = addr[OFS_W-1:0].
  - Misaligned when: h with ofs[0]≠0; w with ofs[1:0]≠0; d with ofs[2:0]≠0 (d legal only when DATA_W=64, otherwise treated as misaligned).
  - Base mask is 1/3/F/FF for b/h/w/d. mask = base << ofs, truncated to NB bits.
  - Store: wmask = dmem_byte_enable = mask; dmem_wdata = req_wdata << (8·ofs); rmask=0.
  - Load: rmask = mask, wmask=0, dmem_byte_enable=0.
- Load extraction: field = dmem_rdata >> (8·ofs).
  - Signed variants (lb/lh/lw on 64) sign-extend from the field MSB to DATA_W.
  - Unsigned variants zero-extend.
  - lw with DATA_W=32 returns the full word.
- Simultaneous events:
  - dmem_resp and rst in the same cycle: reset wins.
  - advance in ACCESS: ignored; stall remains asserted.

Decomposition:
- Package rv32i_types: reuse load_funct3_t and store_funct3_t. Add mem_acc_state_t {IDLE, ACCESS, HOLD} and a funct3 code for ld/sd.
- Sub-module mem_align (combinational, parametrised by DATA_W): mask generation, misalign detect, store lane shift, load extract/extend.
- The FSM, capture registers and result register stay in mem_access_unit.

Test Plan:
1. DATA_W=32, lb at addr 0x1003, rdata 0x80FF_0000, resp after 3 cycles -> dmem_read cycles 1-3, address 0x1000, rmask 1000, load_data 0xFFFF_FF80, done at cycle 4, stall low at cycle 4.
2. sh at addr 0x2002, wdata 0x0000_BEEF -> dmem_write, byte_enable 1100, dmem_wdata 0xBEEF_0000, wmask 1100, no load_data change.
3. lw at 0x3001 -> no dmem_read ever, misaligned=1 and done=1 the next cycle, held until advance.
4. DATA_W=64, lwu at 0x4004, rdata 0x8765_4321_0000_0000 -> load_data 0x0000_0000_8765_4321; ld at 0x4008 -> full dword.
5. Load in HOLD with advance=0 for 5 cycles -> load_data, done and rmask stable; advance=1 -> IDLE, done=0 next cycle.
6. rst asserted mid-ACCESS, then dmem_resp pulse -> strobes drop asynchronously, resp ignored, outputs at reset values.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_pkg
//  Purpose  : Shared types and constants for the MEM-stage access unit:
//             RISC-V load/store funct3 encodings (including ld/sd), the
//             access FSM state type, access-size codes and a base byte-mask
//             helper.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    // Load funct3 encodings; ld/lwu are only meaningful on a 64-bit bus.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } load_funct3_t;

    // Store funct3 encodings; sd only on a 64-bit bus.
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010,
        SD = 3'b011
    } store_funct3_t;

    // Access FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } mem_acc_state_t;

    // funct3[1:0] encodes the access size, funct3[2] marks unsigned loads.
    localparam logic [1:0] c_SIZE_B = 2'd0;
    localparam logic [1:0] c_SIZE_H = 2'd1;
    localparam logic [1:0] c_SIZE_W = 2'd2;
    localparam logic [1:0] c_SIZE_D = 2'd3;
    localparam int         c_F3_UNSIGNED_BIT = 2;

    // Byte mask of an access of the given size placed at lane 0.
    function automatic logic [7:0] f_base_mask(input logic [1:0] size);
        case (size)
            c_SIZE_B: return 8'h01;
            c_SIZE_H: return 8'h03;
            c_SIZE_W: return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

endpackage : mem_access_unit_pkg
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Purpose  : Bundles the EX/MEM request, pipeline control and data-memory
//             port signals of the MEM-stage access unit.
//  Ports    : slave  - used by mem_access_unit (consumes requests/responses,
//                      drives dmem strobes and pipeline status)
//             master - used by the pipeline/memory side
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = DATA_W / 8;

    // EX/MEM request
    logic              req_valid;
    logic              req_load;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              advance;

    // Data-memory port
    logic [ADDR_W-1:0] dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [NB-1:0]     dmem_byte_enable;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;

    // Pipeline status / result
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] load_data;
    logic [NB-1:0]     rmask;
    logic [NB-1:0]     wmask;
    logic              misaligned;

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        input  advance, dmem_rdata, dmem_resp,
        output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        output stall, done, load_data, rmask, wmask, misaligned
    );

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata,
        output advance, dmem_rdata, dmem_resp,
        input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        input  stall, done, load_data, rmask, wmask, misaligned
    );

endinterface : mem_access_unit_if
`default_nettype wire

// File: rtl/mem_access_unit_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_align
//  Purpose  : Combinational lane logic for a single access: byte-mask
//             generation, misalignment detection, store lane shift and
//             load extraction with sign/zero extension.
//  Ports    : i_funct3     - access width/sign code
//             i_ofs        - byte offset within the bus word
//             i_wdata      - right-justified store data
//             i_rdata      - bus read data
//             o_mask       - byte mask of the access on the bus
//             o_misaligned - access does not fit its natural alignment
//             o_wdata      - store data shifted onto its lanes
//             o_load_data  - extracted, extended load value
//  Revision : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFS_W  = $clog2(NB)
) (
    input  wire logic [2:0]        i_funct3,
    input  wire logic [OFS_W-1:0]  i_ofs,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [DATA_W-1:0] i_rdata,
    output logic      [NB-1:0]     o_mask,
    output logic                   o_misaligned,
    output logic      [DATA_W-1:0] o_wdata,
    output logic      [DATA_W-1:0] o_load_data
);

    logic [1:0]        w_size;
    logic              w_unsigned;
    logic [15:0]       w_mask_wide;
    logic [OFS_W+2:0]  w_shamt;
    logic [DATA_W-1:0] w_field;
    logic signed [7:0]  w_b;
    logic signed [15:0] w_h;
    logic signed [31:0] w_w;

    assign w_size     = i_funct3[1:0];
    assign w_unsigned = i_funct3[c_F3_UNSIGNED_BIT];
    assign w_shamt    = {i_ofs, 3'b000};

    // Shift in a wide vector so masks straddling the top lane are simply cut off.
    assign w_mask_wide = {8'h00, f_base_mask(w_size)} << i_ofs;
    assign o_mask      = w_mask_wide[NB-1:0];

    always_comb begin
        o_misaligned = 1'b0;
        case (w_size)
            c_SIZE_B: o_misaligned = 1'b0;
            c_SIZE_H: o_misaligned = i_ofs[0];
            c_SIZE_W: o_misaligned = |i_ofs[1:0];
            // A doubleword never fits a 32-bit bus, so it is always rejected there.
            default:  o_misaligned = (DATA_W == 64) ? (|i_ofs) : 1'b1;
        endcase
    end

    assign o_wdata = i_wdata << w_shamt;

    assign w_field = i_rdata >> w_shamt;
    assign w_b     = w_field[7:0];
    assign w_h     = w_field[15:0];
    assign w_w     = w_field[31:0];

    // Size casts of the signed views sign-extend; of the raw slices zero-extend.
    always_comb begin
        o_load_data = w_field;
        case (w_size)
            c_SIZE_B: o_load_data = w_unsigned ? DATA_W'(w_field[7:0])  : DATA_W'(w_b);
            c_SIZE_H: o_load_data = w_unsigned ? DATA_W'(w_field[15:0]) : DATA_W'(w_h);
            c_SIZE_W: o_load_data = w_unsigned ? DATA_W'(w_field[31:0]) : DATA_W'(w_w);
            default:  o_load_data = w_field;
        endcase
    end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage data-memory access unit. Captures a load/store from
//             EX/MEM, issues it to the data cache with a request/response
//             handshake while stalling the pipeline, suppresses misaligned
//             accesses, and holds the aligned/extended load result until the
//             pipeline advances.
//  Ports    : clk - clock
//             rst - asynchronous active-high reset
//             bus - mem_access_unit_if.slave (request, pipeline control,
//                   dmem port, status and result)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFS_W  = $clog2(NB)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_access_unit_if.slave bus
);

    mem_acc_state_t    r_state;
    mem_acc_state_t    w_next_state;

    // Request captured on entry so ACCESS/HOLD are immune to EX/MEM changes.
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_load;
    logic              r_is_store;
    logic              r_misaligned;
    logic [DATA_W-1:0] r_load_data;

    logic              w_mem_req;
    logic              w_in_idle;
    logic [2:0]        w_al_funct3;
    logic [OFS_W-1:0]  w_al_ofs;
    logic [DATA_W-1:0] w_al_wdata;
    logic [NB-1:0]     w_al_mask;
    logic              w_al_misaligned;
    logic [DATA_W-1:0] w_al_wdata_lane;
    logic [DATA_W-1:0] w_al_load_data;

    assign w_mem_req = bus.req_valid & (bus.req_load | bus.req_store);
    assign w_in_idle = (r_state == IDLE);

    // The lane logic looks at the live request while deciding in IDLE and at
    // the captured copy for the rest of the access, so one instance serves both.
    assign w_al_funct3 = w_in_idle ? bus.req_funct3            : r_funct3;
    assign w_al_ofs    = w_in_idle ? bus.req_addr[OFS_W-1:0]   : r_addr[OFS_W-1:0];
    assign w_al_wdata  = w_in_idle ? bus.req_wdata             : r_wdata;

    mem_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_funct3     (w_al_funct3),
        .i_ofs        (w_al_ofs),
        .i_wdata      (w_al_wdata),
        .i_rdata      (bus.dmem_rdata),
        .o_mask       (w_al_mask),
        .o_misaligned (w_al_misaligned),
        .o_wdata      (w_al_wdata_lane),
        .o_load_data  (w_al_load_data)
    );

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_mem_req) begin
                    w_next_state = w_al_misaligned ? HOLD : ACCESS;
                end
            end
            ACCESS: begin
                // advance is deliberately not looked at: the pipeline is stalled.
                if (bus.dmem_resp) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.advance) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        bus.stall            = 1'b0;
        bus.done             = 1'b0;
        bus.dmem_read        = 1'b0;
        bus.dmem_write       = 1'b0;
        bus.dmem_address     = '0;
        bus.dmem_byte_enable = '0;
        bus.dmem_wdata       = '0;
        bus.rmask            = '0;
        bus.wmask            = '0;
        bus.misaligned       = 1'b0;
        case (r_state)
            IDLE: begin
                bus.stall = w_mem_req;
                // Non-memory instructions complete in MEM without a memory cycle.
                bus.done  = bus.req_valid & ~(bus.req_load | bus.req_store);
            end
            ACCESS: begin
                bus.stall            = 1'b1;
                bus.dmem_read        = r_is_load;
                bus.dmem_write       = r_is_store;
                bus.dmem_address     = {r_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                bus.dmem_byte_enable = r_is_store ? w_al_mask : '0;
                bus.dmem_wdata       = r_is_store ? w_al_wdata_lane : '0;
                bus.rmask            = r_is_load  ? w_al_mask : '0;
                bus.wmask            = r_is_store ? w_al_mask : '0;
            end
            HOLD: begin
                bus.done       = 1'b1;
                bus.misaligned = r_misaligned;
                // A suppressed access touched no bytes.
                bus.rmask      = (r_is_load  & ~r_misaligned) ? w_al_mask : '0;
                bus.wmask      = (r_is_store & ~r_misaligned) ? w_al_mask : '0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Request capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_funct3     <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (w_in_idle && w_mem_req) begin
            r_funct3     <= bus.req_funct3;
            r_addr       <= bus.req_addr;
            r_wdata      <= bus.req_wdata;
            // A malformed load+store entry is treated as a load.
            r_is_load    <= bus.req_load;
            r_is_store   <= bus.req_store & ~bus.req_load;
            r_misaligned <= w_al_misaligned;
        end else if ((r_state == HOLD) && bus.advance) begin
            r_misaligned <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Load result: updated only by a completing load, held otherwise
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_data <= '0;
        end else if ((r_state == ACCESS) && bus.dmem_resp && r_is_load) begin
            r_load_data <= w_al_load_data;
        end
    end

    assign bus.load_data = r_load_data;

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit. Drives a 32-bit and a
//             64-bit instance (one active at a time, chosen by sel) and
//             compares against a byte-arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;          // 0: 32-bit instance, 1: 64-bit instance
    logic        t_valid, t_load, t_store, t_resp, t_adv;
    logic [2:0]  t_f3;
    logic [31:0] t_addr;
    logic [63:0] t_wdata, t_rdata;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_ld [2];

    always #5 clk = ~clk;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    mem_access_unit_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    assign bus32.req_valid  = t_valid & ~sel;
    assign bus32.req_load   = t_load;
    assign bus32.req_store  = t_store;
    assign bus32.req_funct3 = t_f3;
    assign bus32.req_addr   = t_addr;
    assign bus32.req_wdata  = t_wdata[31:0];
    assign bus32.advance    = t_adv & ~sel;
    assign bus32.dmem_rdata = t_rdata[31:0];
    assign bus32.dmem_resp  = t_resp & ~sel;

    assign bus64.req_valid  = t_valid & sel;
    assign bus64.req_load   = t_load;
    assign bus64.req_store  = t_store;
    assign bus64.req_funct3 = t_f3;
    assign bus64.req_addr   = t_addr;
    assign bus64.req_wdata  = t_wdata;
    assign bus64.advance    = t_adv & sel;
    assign bus64.dmem_rdata = t_rdata;
    assign bus64.dmem_resp  = t_resp & sel;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    wire        o_stall = sel ? bus64.stall      : bus32.stall;
    wire        o_done  = sel ? bus64.done       : bus32.done;
    wire        o_mis   = sel ? bus64.misaligned : bus32.misaligned;
    wire        o_rd    = sel ? bus64.dmem_read  : bus32.dmem_read;
    wire        o_wr    = sel ? bus64.dmem_write : bus32.dmem_write;
    wire [31:0] o_addr  = sel ? bus64.dmem_address : bus32.dmem_address;
    wire [7:0]  o_be    = sel ? bus64.dmem_byte_enable : {4'h0, bus32.dmem_byte_enable};
    wire [7:0]  o_rmask = sel ? bus64.rmask : {4'h0, bus32.rmask};
    wire [7:0]  o_wmask = sel ? bus64.wmask : {4'h0, bus32.wmask};
    wire [63:0] o_dwd   = sel ? bus64.dmem_wdata : {32'h0, bus32.dmem_wdata};
    wire [63:0] o_ld    = sel ? bus64.load_data  : {32'h0, bus32.load_data};

    // Reference model: pure byte arithmetic on the access description.
    function automatic void model(input int w, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] rdata,
                                  output logic mis, output logic [7:0] mask,
                                  output logic [63:0] wsh, output logic [63:0] ld);
        int nb, ofs, nbytes, bits;
        logic [63:0] wmsk, field, lo;
        nb     = w / 8;
        ofs    = int'(addr % 32'(nb));
        nbytes = 1 << f3[1:0];
        bits   = 8 * nbytes;
        wmsk   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mis    = ((addr % 32'(nbytes)) != 0) || (bits > w);
        mask   = 8'((((1 << nbytes) - 1) << ofs) & ((1 << nb) - 1));
        wsh    = ((wdata & wmsk) << (8 * ofs)) & wmsk;
        field  = (rdata & wmsk) >> (8 * ofs);
        lo     = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        ld     = field & lo;
        if (!f3[2] && bits < w && ld[bits-1]) ld = ld | ~lo;
        ld     = ld & wmsk;
    endfunction

    // One complete access: request at cycle 0, response after lat cycles,
    // hold for hold+1 cycles with advance on the last. Leaves the DUT
    // entering IDLE with the request still presented.
    task automatic run_access(input logic s, input logic is_load, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [63:0] wdata,
                              input logic [63:0] rdata, input int lat, input int hold,
                              input bit adv_in_access);
        logic mis; logic [7:0] mask; logic [63:0] wsh, ld; logic [31:0] aaddr;
        int w;
        w = s ? 64 : 32;
        model(w, f3, addr, wdata, rdata, mis, mask, wsh, ld);
        aaddr = addr & ~(32'(w / 8) - 32'd1);
        @(negedge clk);
        sel = s; t_valid = 1'b1; t_load = is_load; t_store = ~is_load; t_f3 = f3;
        t_addr = addr; t_wdata = wdata; t_adv = 1'b0; t_resp = 1'b0;
        #1;
        n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL req_stall: got %0b want 1", o_stall); end
        n_checks++; if (o_done !== 1'b0 || o_mis !== 1'b0) begin n_fail++; $display("FAIL req_idle_status: done=%0b mis=%0b want 0/0", o_done, o_mis); end
        n_checks++; if (o_rd !== 1'b0 || o_wr !== 1'b0) begin n_fail++; $display("FAIL req_no_strobe: rd=%0b wr=%0b want 0/0", o_rd, o_wr); end
        n_checks++; if (o_ld !== exp_ld[s]) begin n_fail++; $display("FAIL req_ld_held: got %h want %h", o_ld, exp_ld[s]); end
        if (!mis) begin
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                // Scramble EX/MEM to prove the access runs from captured state.
                t_addr  = $urandom; t_wdata = {$urandom, $urandom}; t_f3 = 3'($urandom);
                t_rdata = (c == lat) ? rdata : {$urandom, $urandom};
                t_resp  = (c == lat);
                t_adv   = adv_in_access ? 1'($urandom) : 1'b0;
                #1;
                n_checks++; if (o_rd !== is_load || o_wr !== ~is_load) begin n_fail++; $display("FAIL acc_strobe c%0d: rd=%0b wr=%0b want %0b/%0b", c, o_rd, o_wr, is_load, ~is_load); end
                n_checks++; if (o_addr !== aaddr) begin n_fail++; $display("FAIL acc_addr: got %h want %h", o_addr, aaddr); end
                n_checks++; if (o_stall !== 1'b1 || o_done !== 1'b0) begin n_fail++; $display("FAIL acc_stall: stall=%0b done=%0b want 1/0", o_stall, o_done); end
                if (is_load) begin
                    n_checks++; if (o_rmask !== mask || o_wmask !== 8'h0 || o_be !== 8'h0) begin n_fail++; $display("FAIL acc_ld_mask: rmask=%h wmask=%h be=%h want %h/00/00", o_rmask, o_wmask, o_be, mask); end
                end else begin
                    n_checks++; if (o_be !== mask || o_wmask !== mask || o_rmask !== 8'h0) begin n_fail++; $display("FAIL acc_st_mask: be=%h wmask=%h rmask=%h want %h/%h/00", o_be, o_wmask, o_rmask, mask, mask); end
                    n_checks++; if (o_dwd !== wsh) begin n_fail++; $display("FAIL acc_st_wdata: got %h want %h", o_dwd, wsh); end
                end
            end
            if (is_load) exp_ld[s] = ld;
        end
        for (int c = 0; c <= hold; c++) begin
            @(negedge clk);
            t_resp = 1'b0; t_adv = (c == hold); t_rdata = {$urandom, $urandom};
            #1;
            n_checks++; if (o_done !== 1'b1 || o_stall !== 1'b0) begin n_fail++; $display("FAIL hold_done: done=%0b stall=%0b want 1/0", o_done, o_stall); end
            n_checks++; if (o_rd !== 1'b0 || o_wr !== 1'b0) begin n_fail++; $display("FAIL hold_strobe: rd=%0b wr=%0b want 0/0", o_rd, o_wr); end
            n_checks++; if (o_mis !== mis) begin n_fail++; $display("FAIL hold_mis: got %0b want %0b", o_mis, mis); end
            n_checks++; if (o_ld !== exp_ld[s]) begin n_fail++; $display("FAIL hold_ld: got %h want %h", o_ld, exp_ld[s]); end
            if (!mis) begin
                n_checks++; if (o_rmask !== (is_load ? mask : 8'h0) || o_wmask !== (is_load ? 8'h0 : mask)) begin n_fail++; $display("FAIL hold_masks: rmask=%h wmask=%h mask=%h load=%0b", o_rmask, o_wmask, mask, is_load); end
            end
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        t_valid = 1'b0; t_adv = 1'b0; t_resp = 1'b0;
        #1;
        n_checks++; if (o_done !== 1'b0 || o_mis !== 1'b0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL %s_idle: done=%0b mis=%0b stall=%0b want 0/0/0", tag, o_done, o_mis, o_stall); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s); t_valid = 1'b0; #1;
            n_checks++; if (o_rd !== 1'b0 || o_wr !== 1'b0 || o_addr !== 32'h0 || o_be !== 8'h0 || o_dwd !== 64'h0) begin n_fail++; $display("FAIL reset_dmem s%0d: rd=%0b wr=%0b addr=%h be=%h wd=%h want zeros", s, o_rd, o_wr, o_addr, o_be, o_dwd); end
            n_checks++; if (o_done !== 1'b0 || o_ld !== 64'h0 || o_mis !== 1'b0 || o_rmask !== 8'h0 || o_wmask !== 8'h0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL reset_status s%0d: done=%0b ld=%h mis=%0b rm=%h wm=%h stall=%0b want zeros", s, o_done, o_ld, o_mis, o_rmask, o_wmask, o_stall); end
            t_valid = 1'b1; t_load = 1'b1; #1;
            n_checks++; if (o_stall !== 1'b1 || o_rd !== 1'b0) begin n_fail++; $display("FAIL reset_stall_req s%0d: stall=%0b rd=%0b want 1/0", s, o_stall, o_rd); end
        end
        t_valid = 1'b0; sel = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        run_access(1'b0, 1'b1, 3'b000, 32'h0000_1003, 64'h0, 64'h0000_0000_80FF_0000, 3, 0, 1'b0);
        n_checks++; if (o_ld !== 64'h0000_0000_FFFF_FF80) begin n_fail++; $display("FAIL dir_lb: got %h want ffffff80", o_ld); end
        run_access(1'b0, 1'b0, 3'b001, 32'h0000_2002, 64'h0000_BEEF, 64'h0, 2, 1, 1'b1);
        n_checks++; if (o_ld !== 64'h0000_0000_FFFF_FF80) begin n_fail++; $display("FAIL dir_sh_keep_ld: got %h want ffffff80", o_ld); end
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_3001, 64'h0, 64'h0, 1, 3, 1'b0);
        run_access(1'b1, 1'b1, 3'b110, 32'h0000_4004, 64'h0, 64'h8765_4321_0000_0000, 1, 0, 1'b0);
        n_checks++; if (o_ld !== 64'h0000_0000_8765_4321) begin n_fail++; $display("FAIL dir_lwu64: got %h want 0000000087654321", o_ld); end
        run_access(1'b1, 1'b1, 3'b011, 32'h0000_4008, 64'h0, 64'hFEDC_BA98_7654_3210, 2, 5, 1'b0);
        n_checks++; if (o_ld !== 64'hFEDC_BA98_7654_3210) begin n_fail++; $display("FAIL dir_ld64: got %h want fedcba9876543210", o_ld); end
        check_idle("dir");
    endtask

    task automatic test_non_mem_and_idle_resp;
        @(negedge clk);
        sel = 1'b0; t_valid = 1'b1; t_load = 1'b0; t_store = 1'b0; #1;
        n_checks++; if (o_done !== 1'b1 || o_stall !== 1'b0 || o_rd !== 1'b0) begin n_fail++; $display("FAIL nonmem: done=%0b stall=%0b rd=%0b want 1/0/0", o_done, o_stall, o_rd); end
        @(negedge clk);
        t_valid = 1'b0; t_resp = 1'b1; t_rdata = 64'h1111_2222_3333_4444; #1;
        n_checks++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL idle_done: got %0b want 0", o_done); end
        @(negedge clk);
        t_resp = 1'b0; #1;
        n_checks++; if (o_ld !== exp_ld[0] || o_done !== 1'b0 || o_rd !== 1'b0) begin n_fail++; $display("FAIL idle_resp_ignored: ld=%h done=%0b rd=%0b want %h/0/0", o_ld, o_done, o_rd, exp_ld[0]); end
    endtask

    task automatic test_back_to_back;
        run_access(1'b1, 1'b0, 3'b011, 32'h0000_5000, 64'h0123_4567_89AB_CDEF, 64'h0, 1, 0, 1'b0);
        run_access(1'b1, 1'b1, 3'b000, 32'h0000_5005, 64'h0, 64'h0000_7F00_0000_0000, 1, 0, 1'b0);
        run_access(1'b1, 1'b1, 3'b101, 32'h0000_5006, 64'h0, 64'h9ABC_0000_0000_0000, 1, 0, 1'b0);
        run_access(1'b0, 1'b0, 3'b000, 32'h0000_6001, 64'h0000_00A5, 64'h0, 1, 0, 1'b0);
        check_idle("b2b");
    endtask

    task automatic test_random;
        logic s, ld; logic [2:0] f3; logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            s  = 1'($urandom);
            ld = 1'($urandom);
            f3 = ld ? 3'($urandom_range(0, 6)) : 3'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a = a & ~(32'h7 >> $urandom_range(0, 2));
            run_access(s, ld, f3, a, {$urandom, $urandom}, {$urandom, $urandom},
                       $urandom_range(1, 4), $urandom_range(0, 3), 1'($urandom));
        end
        check_idle("rand");
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk);
        sel = 1'b0; t_valid = 1'b1; t_load = 1'b1; t_store = 1'b0; t_f3 = 3'b010;
        t_addr = 32'h0000_1000; t_resp = 1'b0; t_adv = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (o_rd !== 1'b1) begin n_fail++; $display("FAIL rstmid_read_up: got %0b want 1", o_rd); end
        @(negedge clk); #2;
        rst = 1'b1; #1;
        n_checks++; if (o_rd !== 1'b0 || o_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_async_drop: rd=%0b addr=%h want 0/0", o_rd, o_addr); end
        t_valid = 1'b0; t_resp = 1'b1; t_rdata = 64'h0000_0000_DEAD_BEEF;
        @(negedge clk);
        t_resp = 1'b0; #1;
        exp_ld[0] = 64'h0; exp_ld[1] = 64'h0;
        n_checks++; if (o_ld !== 64'h0 || o_done !== 1'b0 || o_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_resp_ignored: ld=%h done=%0b stall=%0b want 0/0/0", o_ld, o_done, o_stall); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (o_ld !== 64'h0 || o_done !== 1'b0 || o_rd !== 1'b0 || o_mis !== 1'b0 || o_rmask !== 8'h0) begin n_fail++; $display("FAIL rstmid_after: ld=%h done=%0b rd=%0b mis=%0b rm=%h want zeros", o_ld, o_done, o_rd, o_mis, o_rmask); end
        sel = 1'b1; #1;
        n_checks++; if (o_ld !== 64'h0) begin n_fail++; $display("FAIL rstmid_ld64: got %h want 0", o_ld); end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0;
        t_valid = 1'b0; t_load = 1'b0; t_store = 1'b0; t_resp = 1'b0; t_adv = 1'b0;
        t_f3 = 3'b000; t_addr = 32'h0; t_wdata = 64'h0; t_rdata = 64'h0;
        exp_ld[0] = 64'h0; exp_ld[1] = 64'h0;
        test_reset;
        test_directed;
        test_non_mem_and_idle_resp;
        test_back_to_back;
        test_random;
        test_reset_mid_access;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_access_unit
`default_nettype wire
